// File: rtl/md_ctrl.sv
// HI/LO owner and multi-cycle mult/multu/div/divu sequencer for the E stage; generates the D-stage stall.
// Define MDU_DIV_EN to build the divider (div/divu); without it op_e 3/4 behave as no-ops.
module md_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [2:0]  op_e,
   input  logic [31:0] a_e,
   input  logic [31:0] b_e,
   input  logic        md_use_d,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    hi_q, hi_d, lo_q, lo_d;
   logic [31:0]    res_hi_q, res_hi_d, res_lo_q, res_lo_d;
   logic           sup_q, sup_d;

   logic           is_mul, is_div, start;
   logic [63:0]    prod_s, prod_u;

   assign is_mul = (op_e == 3'd1) || (op_e == 3'd2);
   assign prod_s = $signed({{32{a_e[31]}}, a_e}) * $signed({{32{b_e[31]}}, b_e});
   assign prod_u = {32'd0, a_e} * {32'd0, b_e};

`ifdef MDU_DIV_EN
   logic [31:0] dvs, quo_s, rem_s, quo_u, rem_u;

   assign is_div = (op_e == 3'd3) || (op_e == 3'd4);
   // A zero divisor is replaced so the datapath never produces X; that result is discarded anyway.
   assign dvs    = (b_e == 32'd0) ? 32'd1 : b_e;
   assign quo_s  = $signed(a_e) / $signed(dvs);
   assign rem_s  = $signed(a_e) % $signed(dvs);
   assign quo_u  = a_e / dvs;
   assign rem_u  = a_e % dvs;
`else
   assign is_div = 1'b0;
`endif

   assign start = (is_mul || is_div) && (state_q == IDLE);
   assign busy  = (state_q == RUN);
   assign stall = md_use_d && (busy || is_mul || is_div);
   assign hi    = hi_q;
   assign lo    = lo_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      sup_d    = sup_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               sup_d   = 1'b0;
               cnt_d   = CW'(MULT_CYCLES);
               case (op_e)
                  3'd1:    {res_hi_d, res_lo_d} = prod_s;
                  3'd2:    {res_hi_d, res_lo_d} = prod_u;
`ifdef MDU_DIV_EN
                  3'd3: begin
                     res_hi_d = rem_s;
                     res_lo_d = quo_s;
                  end
                  3'd4: begin
                     res_hi_d = rem_u;
                     res_lo_d = quo_u;
                  end
`endif
                  default: ;
               endcase
               if (is_div) begin
                  cnt_d = CW'(DIV_CYCLES);
                  sup_d = (b_e == 32'd0);
               end
            end else if (op_e == 3'd5) begin
               hi_d = a_e;
            end else if (op_e == 3'd6) begin
               lo_d = a_e;
            end
         end
         RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = IDLE;
               if (!sup_q) begin
                  hi_d = res_hi_q;
                  lo_d = res_lo_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         sup_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         sup_q    <= sup_d;
      end
   end

endmodule

// File: tb/tb_md_ctrl.sv
// Randomized and directed bench for md_ctrl against an arithmetic model of HI/LO.
module tb_md_ctrl;

   localparam int MN = 5;
   localparam int DN = 10;

   logic        clk;
   logic        clr;
   logic [2:0]  op_e;
   logic [31:0] a_e, b_e;
   logic        md_use_d;
   logic        busy, stall;
   logic [31:0] hi, lo;

   int vectors;
   int miscompares;
   logic [31:0] exp_hi, exp_lo;

   md_ctrl #(.MULT_CYCLES(MN), .DIV_CYCLES(DN)) dut (
      .clk(clk), .clr(clr), .op_e(op_e), .a_e(a_e), .b_e(b_e),
      .md_use_d(md_use_d), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: architectural effect of one op on HI/LO and its busy length.
   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l, output int n);
      longint          sp;
      longint unsigned up;
      int              sa, sb;
      n = 0;
      case (op)
         3'd1: begin
            sa = a; sb = b;
            sp = longint'(sa) * longint'(sb);
            h = sp[63:32]; l = sp[31:0]; n = MN;
         end
         3'd2: begin
            up = 64'(a) * 64'(b);
            h = up[63:32]; l = up[31:0]; n = MN;
         end
`ifdef MDU_DIV_EN
         3'd3: begin
            n = DN;
            if (b != 0) begin
               sa = a; sb = b;
               l = sa / sb; h = sa % sb;
            end
         end
         3'd4: begin
            n = DN;
            if (b != 0) begin
               l = a / b; h = a % b;
            end
         end
`endif
         3'd5: h = a;
         3'd6: l = a;
         default: ;
      endcase
   endfunction

   // Called at a negedge; returns at the first negedge with busy low.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n, output logic hold_bad);
      logic [31:0] h0, l0;
      h0 = hi; l0 = lo;
      op_e = op; a_e = a; b_e = b;
      @(posedge clk);
      @(negedge clk);
      op_e = 3'd0;
      n = 0;
      hold_bad = 1'b0;
      while (busy === 1'b1 && n < 100) begin
         if (hi !== h0 || lo !== l0) hold_bad = 1'b1;
         n++;
         @(negedge clk);
      end
   endtask

   task automatic check_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int n, en;
      logic bad;
      model(op, a, b, exp_hi, exp_lo, en);
      run_op(op, a, b, n, bad);
      vectors++;
      if (n !== en) begin
         miscompares++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, en);
      end
      vectors++;
      if (bad !== 1'b0) begin
         miscompares++;
         $display("FAIL %s hold: HI/LO changed while busy", name);
      end
      vectors++;
      if (hi !== exp_hi || lo !== exp_lo) begin
         miscompares++;
         $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
      end
   endtask

   task automatic test_reset;
      clr = 1'b0; op_e = 3'd0; a_e = '0; b_e = '0; md_use_d = 1'b0;
      #12;
      vectors++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: busy=%b stall=%b hi=%h lo=%h expected 0", busy, stall, hi, lo);
      end
      md_use_d = 1'b1;
      #1;
      vectors++;
      if (stall !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_stall: got %b expected 0", stall);
      end
      md_use_d = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      exp_hi = '0; exp_lo = '0;
      @(negedge clk);
   endtask

   task automatic test_mult;
      check_op("mult", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
      check_op("multu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
   endtask

   task automatic test_div;
      check_op("div", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
      check_op("divu", 3'd4, 32'h0000_0007, 32'h0000_0002);
      md_use_d = 1'b1; op_e = 3'd3; #1;
      vectors++;
`ifdef MDU_DIV_EN
      if (stall !== 1'b1) begin
`else
      if (stall !== 1'b0) begin
`endif
         miscompares++;
         $display("FAIL div_stall: got %b", stall);
      end
      op_e = 3'd0; md_use_d = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_divzero;
      check_op("mthi", 3'd5, 32'h0000_0012, 32'h0);
      check_op("mtlo", 3'd6, 32'h0000_0034, 32'h0);
      check_op("div_by_zero", 3'd3, 32'h0000_0005, 32'h0);
      repeat (2) @(negedge clk);
      vectors++;
      if (hi !== 32'h12 || lo !== 32'h34) begin
         miscompares++;
         $display("FAIL div_by_zero_late: got hi=%h lo=%h expected hi=00000012 lo=00000034", hi, lo);
      end
   endtask

   task automatic test_stall;
      int n, en;
      logic bad;
      for (int use_d = 1; use_d >= 0; use_d--) begin
         md_use_d = 1'(use_d);
         model(3'd1, 32'h0000_1234, 32'h0000_0056, exp_hi, exp_lo, en);
         op_e = 3'd1; a_e = 32'h0000_1234; b_e = 32'h0000_0056;
         #1;
         vectors++;
         if (stall !== 1'(use_d)) begin
            miscompares++;
            $display("FAIL stall_start(use=%0d): got %b expected %0d", use_d, stall, use_d);
         end
         @(posedge clk);
         @(negedge clk);
         op_e = 3'd0;
         n = 0; bad = 1'b0;
         while (busy === 1'b1 && n < 100) begin
            if (stall !== 1'(use_d)) bad = 1'b1;
            n++;
            @(negedge clk);
         end
         vectors++;
         if (n !== en || bad !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_run(use=%0d): busy_cycles=%0d bad=%b stall_after=%b expected %0d/0/0", use_d, n, bad, stall, en);
         end
      end
      md_use_d = 1'b0;
   endtask

   task automatic test_ignore_busy;
      int n, en;
      model(3'd1, 32'h0000_0003, 32'hFFFF_FFFB, exp_hi, exp_lo, en);
      op_e = 3'd1; a_e = 32'h0000_0003; b_e = 32'hFFFF_FFFB;
      @(posedge clk);
      @(negedge clk);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         op_e = (n == 1) ? 3'd1 : (n == 2) ? 3'd6 : 3'd0;
         a_e = 32'h7777_0000; b_e = 32'h0000_0009;
         @(negedge clk);
      end
      op_e = 3'd0;
      vectors++;
      if (n !== en || hi !== exp_hi || lo !== exp_lo) begin
         miscompares++;
         $display("FAIL ignore_busy: cycles=%0d hi=%h lo=%h expected %0d hi=%h lo=%h", n, hi, lo, en, exp_hi, exp_lo);
      end
   endtask

   task automatic test_reset_mid;
      logic bad;
      check_op("pre_mthi", 3'd5, 32'hAAAA_5555, 32'h0);
      check_op("pre_mtlo", 3'd6, 32'h5555_AAAA, 32'h0);
      op_e = 3'd1; a_e = 32'h4000_0000; b_e = 32'h0000_0013;
      @(posedge clk);
      @(negedge clk);
      op_e = 3'd0;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid_pre: busy=%b expected 1", busy);
      end
      #2 clr = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_mid_async: busy=%b hi=%h lo=%h expected 0", busy, hi, lo);
      end
      @(posedge clk);
      @(negedge clk);
      clr = 1'b1;
      exp_hi = '0; exp_lo = '0;
      bad = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad = 1'b1;
      end
      vectors++;
      if (bad !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_after: late commit or busy after release (busy=%b hi=%h lo=%h)", busy, hi, lo);
      end
   endtask

   task automatic test_random;
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(6, 1));
         a  = $urandom;
         case ($urandom_range(3, 0))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(9, 1));
            2:       b = -32'($urandom_range(9, 1));
            default: b = $urandom;
         endcase
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
         check_op("random", op, a, b);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_mult();
      test_div();
      test_divzero();
      test_stall();
      test_ignore_busy();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
